nbbpu_lsu: RTL and testbench

- Load/store initiator between the NBBPU core datapath and the 16-bit single-port data RAM (256 x 16-bit words, combinational read, write on clock rising edge when control[0]=1, whole-word writes only).
- Accepts byte-addressed word/byte load and store requests from the core over a valid/ready handshake and issues the matching RAM cycles.
- Byte stores become read-modify-write sequences.
- Returns load data or a fault over a valid/ready response channel.

---
 rtl/nbbpu_lsu.sv | 160 ++++++++++++++++
 tb/tb_nbbpu_lsu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nbbpu_lsu.sv
// Load/store initiator between the NBBPU core and a 16-bit single-port data RAM.
// Word/byte loads and stores; byte stores are read-modify-write; faults answer without touching RAM.
module nbbpu_lsu #(
  parameter int RAM_WORDS   = 256,
  parameter bit SIGN_EXTEND = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_address,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_error,
  output logic        ram_control,
  output logic [15:0] ram_address,
  output logic [15:0] ram_write_data,
  input  logic [15:0] ram_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam logic [16:0] ADDR_LIMIT = 17'(2 * RAM_WORDS);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        addr_lsb_q, addr_lsb_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;

  logic        accept_s;
  logic        fault_s;
  logic [7:0]  byte_sel_s;
  logic [15:0] load_val_s;

  // RAM strobes and handshake flags decode straight from the state register,
  // so an asynchronous reset kills a write in flight.
  assign req_ready      = (state_q == IDLE) && reset_n;
  assign resp_valid     = (state_q == RESPOND);
  assign ram_control    = (state_q == WRITE);
  assign resp_data      = resp_data_q;
  assign resp_error     = resp_error_q;
  assign ram_address    = ram_addr_q;
  assign ram_write_data = ram_wdata_q;

  assign accept_s = req_valid && req_ready;
  assign fault_s  = (!req_byte && req_address[0]) || ({1'b0, req_address} >= ADDR_LIMIT);

  // Byte lane select and extension of the word currently on the RAM read bus
  always_comb begin
    byte_sel_s = addr_lsb_q ? ram_read_data[15:8] : ram_read_data[7:0];
    if (!byte_q) begin
      load_val_s = ram_read_data;
    end else if (SIGN_EXTEND) begin
      load_val_s = {{8{byte_sel_s[7]}}, byte_sel_s};
    end else begin
      load_val_s = {8'h00, byte_sel_s};
    end
  end

  // Next-state and datapath updates for the request sequencer
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    byte_d       = byte_q;
    addr_lsb_d   = addr_lsb_q;
    data_d       = data_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          write_d      = req_write;
          byte_d       = req_byte;
          addr_lsb_d   = req_address[0];
          data_d       = req_data[7:0];
          resp_data_d  = 16'h0000;
          resp_error_d = fault_s;
          if (fault_s) begin
            state_d = RESPOND;
          end else if (req_write && !req_byte) begin
            ram_addr_d  = {1'b0, req_address[15:1]};
            ram_wdata_d = req_data;
            state_d     = WRITE;
          end else begin
            ram_addr_d = {1'b0, req_address[15:1]};
            state_d    = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Byte stores merge the untouched lane from the word just read
        if (write_q) begin
          ram_wdata_d = addr_lsb_q ? {data_q, ram_read_data[7:0]}
                                   : {ram_read_data[15:8], data_q};
          state_d     = WRITE;
        end else begin
          resp_data_d = load_val_s;
          state_d     = RESPOND;
        end
      end
      WRITE: begin
        state_d = RESPOND;
      end
      RESPOND: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESPOND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      addr_lsb_q   <= 1'b0;
      data_q       <= 8'h00;
      resp_data_q  <= 16'h0000;
      resp_error_q <= 1'b0;
      ram_addr_q   <= 16'h0000;
      ram_wdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      addr_lsb_q   <= addr_lsb_d;
      data_q       <= data_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_nbbpu_lsu.sv
// Self-checking bench for nbbpu_lsu: two instances (zero- and sign-extending byte loads),
// each with its own behavioural RAM, driven identically; responses checked from a scoreboard.
module tb_nbbpu_lsu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] req_address = 16'h0000;
  logic [15:0] req_data = 16'h0000;
  logic        resp_ready = 1'b0;

  logic        req_ready_s      [2];
  logic        resp_valid_s     [2];
  logic [15:0] resp_data_s      [2];
  logic        resp_error_s     [2];
  logic        ram_control_s    [2];
  logic [15:0] ram_address_s    [2];
  logic [15:0] ram_write_data_s [2];
  logic [15:0] ram_read_data_s  [2];

  logic [15:0] mem [2][256];
  int          wr_cnt  [2];
  logic [15:0] last_wa [2];
  logic [15:0] last_wd [2];

  logic        poke_en = 1'b0;
  logic [7:0]  poke_a = 8'h00;
  logic [15:0] poke_d = 16'h0000;

  logic [16:0] q_exp [2][$];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  nbbpu_lsu #(.RAM_WORDS(256), .SIGN_EXTEND(1'b0)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready_s[0]), .req_write(req_write), .req_byte(req_byte),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid_s[0]), .resp_ready(resp_ready), .resp_data(resp_data_s[0]), .resp_error(resp_error_s[0]),
    .ram_control(ram_control_s[0]), .ram_address(ram_address_s[0]),
    .ram_write_data(ram_write_data_s[0]), .ram_read_data(ram_read_data_s[0])
  );

  nbbpu_lsu #(.RAM_WORDS(256), .SIGN_EXTEND(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready_s[1]), .req_write(req_write), .req_byte(req_byte),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid_s[1]), .resp_ready(resp_ready), .resp_data(resp_data_s[1]), .resp_error(resp_error_s[1]),
    .ram_control(ram_control_s[1]), .ram_address(ram_address_s[1]),
    .ram_write_data(ram_write_data_s[1]), .ram_read_data(ram_read_data_s[1])
  );

  assign ram_read_data_s[0] = mem[0][ram_address_s[0][7:0]];
  assign ram_read_data_s[1] = mem[1][ram_address_s[1][7:0]];

  // Behavioural RAMs: write on rising edge while control bit 0 is set
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (poke_en) begin
        mem[i][poke_a] <= poke_d;
      end else if (ram_control_s[i]) begin
        mem[i][ram_address_s[i][7:0]] <= ram_write_data_s[i];
        wr_cnt[i]  <= wr_cnt[i] + 1;
        last_wa[i] <= ram_address_s[i];
        last_wd[i] <= ram_write_data_s[i];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    @(posedge clock);
    #1;
    poke_en = 1'b0;
  endtask

  // One request through both instances; e0/e1 are the expected data for SIGN_EXTEND 0/1
  task automatic do_req(input string tag, input logic w, input logic b, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] e0, input logic [15:0] e1,
                        input logic err, input int lat_exp, input int stall);
    int lat;
    logic [16:0] exp;
    check_eq({tag, "_ready"}, {31'd0, req_ready_s[0]}, 32'd1);
    req_valid   = 1'b1;
    req_write   = w;
    req_byte    = b;
    req_address = a;
    req_data    = d;
    q_exp[0].push_back({err, e0});
    q_exp[1].push_back({err, e1});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, req_ready_s[0]}, 32'd0);
    lat = 1;
    while (!resp_valid_s[0] && lat < 16) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, lat_exp);
    for (int k = 0; k < stall; k++) begin
      check_eq({tag, "_stall_valid"}, {31'd0, resp_valid_s[0]}, 32'd1);
      check_eq({tag, "_stall_ready"}, {31'd0, req_ready_s[0]}, 32'd0);
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      if (q_exp[i].size() > 0) begin
        exp = q_exp[i].pop_front();
        check_eq({tag, "_valid"}, {31'd0, resp_valid_s[i]}, 32'd1);
        check_eq({tag, "_data"}, {16'd0, resp_data_s[i]}, {16'd0, exp[15:0]});
        check_eq({tag, "_err"}, {31'd0, resp_error_s[i]}, {31'd0, exp[16]});
      end
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    check_eq({tag, "_idle_ready"}, {31'd0, req_ready_s[0]}, 32'd1);
    check_eq({tag, "_idle_valid"}, {31'd0, resp_valid_s[0]}, 32'd0);
  endtask

  initial begin
    int wc;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    #12;
    check_eq("rst_ready", {31'd0, req_ready_s[0]}, 32'd0);
    check_eq("rst_valid", {31'd0, resp_valid_s[0]}, 32'd0);
    check_eq("rst_ctrl", {31'd0, ram_control_s[0]}, 32'd0);
    check_eq("rst_addr", {16'd0, ram_address_s[0]}, 32'd0);
    check_eq("rst_wdata", {16'd0, ram_write_data_s[0]}, 32'd0);
    check_eq("rst_rdata", {16'd0, resp_data_s[0]}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    poke(8'h10, 16'hBEEF);
    wc = wr_cnt[0];
    do_req("wload", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 2, 0);
    check_eq("wload_nowrite", wr_cnt[0], wc);

    wc = wr_cnt[0];
    do_req("bstore_hi", 1'b1, 1'b1, 16'h0021, 16'h0055, 16'h0000, 16'h0000, 1'b0, 3, 0);
    check_eq("bstore_hi_cnt", wr_cnt[0], wc + 1);
    check_eq("bstore_hi_wa", {16'd0, last_wa[0]}, 32'h0010);
    check_eq("bstore_hi_wd", {16'd0, last_wd[0]}, 32'h55EF);
    check_eq("bstore_hi_mem", {16'd0, mem[0][8'h10]}, 32'h55EF);

    do_req("bstore_lo", 1'b1, 1'b1, 16'h0020, 16'hAA66, 16'h0000, 16'h0000, 1'b0, 3, 0);
    check_eq("bstore_lo_mem", {16'd0, mem[0][8'h10]}, 32'h5566);

    poke(8'h10, 16'h80EF);
    do_req("bload_hi", 1'b0, 1'b1, 16'h0021, 16'h0000, 16'h0080, 16'hFF80, 1'b0, 2, 0);
    do_req("bload_lo", 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h00EF, 16'hFFEF, 1'b0, 2, 0);

    wc = wr_cnt[0];
    do_req("misalign", 1'b1, 1'b0, 16'h0003, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1, 0);
    check_eq("misalign_nowrite", wr_cnt[0], wc);
    do_req("range", 1'b0, 1'b1, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1, 0);
    poke(8'hFF, 16'h7A11);
    do_req("lastbyte", 1'b0, 1'b1, 16'h01FF, 16'h0000, 16'h007A, 16'h007A, 1'b0, 2, 0);

    wc = wr_cnt[0];
    do_req("wstore", 1'b1, 1'b0, 16'h0040, 16'hA5A5, 16'h0000, 16'h0000, 1'b0, 2, 5);
    check_eq("wstore_once", wr_cnt[0], wc + 1);
    check_eq("wstore_mem", {16'd0, mem[0][8'h20]}, 32'hA5A5);
    do_req("b2b_load", 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0, 2, 0);

    // Reset asserted in the middle of a byte store's WRITE cycle
    poke(8'h30, 16'h1111);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_byte    = 1'b1;
    req_address = 16'h0061;
    req_data    = 16'h0099;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    check_eq("rstw_ctrl_on", {31'd0, ram_control_s[0]}, 32'd1);
    check_eq("rstw_addr", {16'd0, ram_address_s[0]}, 32'h0030);
    wc = wr_cnt[0];
    reset_n = 1'b0;
    #1;
    check_eq("rstw_ctrl_off", {31'd0, ram_control_s[0]}, 32'd0);
    check_eq("rstw_ready", {31'd0, req_ready_s[0]}, 32'd0);
    check_eq("rstw_valid", {31'd0, resp_valid_s[0]}, 32'd0);
    check_eq("rstw_raddr", {16'd0, ram_address_s[0]}, 32'd0);
    check_eq("rstw_wdata", {16'd0, ram_write_data_s[0]}, 32'd0);
    @(posedge clock);
    #1;
    check_eq("rstw_nowrite", wr_cnt[0], wc);
    check_eq("rstw_mem", {16'd0, mem[0][8'h30]}, 32'h1111);
    reset_n = 1'b1;
    #1;
    check_eq("rstw_ready_after", {31'd0, req_ready_s[0]}, 32'd1);
    @(posedge clock);
    #1;
    do_req("post_rst", 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h1111, 16'h1111, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
